pid_term_gen: RTL and testbench
===============================

Name: pid_term_gen

Overview:
Upstream stage of the PID adder tree; produces the three incremental-PID terms that the 17-bit registered adders sum.
- Accepts setpoint/feedback samples with a valid/ready handshake and keeps the error history e1 = e(k-1), e2 = e(k-2).
- Computes P = Kp*(e-e1), I = Ki*e and D = Kd*(e-2*e1+e2) with one shared multiplier under a small FSM.
- Presents all three terms as saturated signed 16-bit values with a one-cycle valid pulse.

Parameters:
DW, 16, data/term width (signed two's complement)
CW, 16, coefficient width (signed, fixed point)
FRAC, 8, coefficient fractional bits (0x0100 = 1.0 at default)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  sample valid
in_ready  out  1  high only in IDLE
setpoint  in  DW  signed target
feedback  in  DW  signed measurement
kp, ki, kd  in  CW each  signed coefficients, latched at acceptance
clear_hist  in  1  zero e1/e2; honoured only while in_ready=1
out_valid  out  1  one-cycle pulse, terms valid
p_term, i_term, d_term  out  DW each  signed saturated terms, held until next out_valid
sat  out  1  any saturation in this computation; valid with out_valid, held with terms

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM to IDLE.
  - e1, e2, latched operands, p/i/d_term, sat and out_valid all 0.
  - in_ready is 1 after the reset cycle.
  - Reset mid-computation aborts: no out_valid, history cleared.
- FSM states: IDLE -> DIFF -> MUL_P -> MUL_I -> MUL_D -> DONE -> IDLE. Transitions are unconditional except IDLE, which leaves only on in_valid.
- Accept:
  - Sample is accepted when in_valid && in_ready (cycle 0).
  - Latch setpoint, feedback, kp, ki, kd.
  - in_valid while busy is ignored; no queueing.
- DIFF (cycle 1):
  - e = sat16(setpoint - feedback), computed at 17 bits.
  - dp = sat16(e - e1), computed at 17 bits.
  - dd = sat16(e - 2*e1 + e2), computed at 18 bits.
- MUL_P, MUL_I, MUL_D (cycles 2, 3, 4):
  - 32-bit product, then arithmetic shift right by FRAC (floor toward -inf), then sat16.
  - Result is registered into the p, i or d holding register respectively.
- DONE (cycle 5):
  - Output registers update and out_valid=1 for exactly this cycle.
  - History shifts: e2<=e1, e1<=e.
  - Back-to-back throughput: one sample per 6 cycles.
- sat16: clamp to [-32768, 32767]. sat = OR of all six saturation events of the sample.
- clear_hist:
  - In IDLE without in_valid: e1=e2=0 next cycle.
  - With a concurrent accept: history is cleared and that sample computes with e1=e2=0.
  - While busy: ignored.
- Coefficient or setpoint changes during computation have no effect until the next accept.

Optional Feature:
PID_TERM_DEADBAND_EN:
- Defined: adds parameter DEADBAND (default 4). In DIFF, if |e| <= DEADBAND then e is forced to 0 before dp/dd and before the history update.
- Undefined: the raw saturated e is used. No extra parameter, no logic.

Decomposition:
- Package pid_pkg holds:
  - DW/CW/FRAC defaults
  - FSM state enum (IDLE, DIFF, MUL_P, MUL_I, MUL_D, DONE)
  - SAT_MAX/SAT_MIN constants
  - sat16 function
- Sub-module pid_mul_sat: combinational signed CW x DW multiply, shift by FRAC, saturate to DW, with a sat flag. It is instantiated once and operand-muxed by state.

Test Plan:
- Reset, kp=0x0100, ki=kd=0, sp=1000, fb=400 -> out_valid 5 cycles after accept; p=600, i=0, d=0, sat=0.
- Continue with sp=1000, fb=700 -> p=-300.
- Then kd=0x0100, kp=0, same sample (e=300, e1=300, e2=600) -> d=300-600+600=300.
- ki=0x0080 (0.5), e=-3 -> i_term=-2 (floor).
- sp=32767, fb=-32768, kp=0x0100 -> e clamps to 32767, p=32767, sat=1.
- kp=0x7FFF, e=1000 -> p=32767, sat=1.
- in_valid held high continuously -> accepts spaced exactly 6 cycles; in_ready low in cycles 1-5.
- rst_n low in MUL_I -> no out_valid, outputs 0.
- Next sample computes with e1=e2=0.
- clear_hist with accept of e=50 after history e1=200 -> p=50 (kp=1.0).
- clear_hist asserted while busy -> no effect.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared defaults, FSM encoding and 16-bit saturation helpers for the PID term generator.
package pid_pkg;

   localparam int DW_DEF   = 16;
   localparam int CW_DEF   = 16;
   localparam int FRAC_DEF = 8;
   localparam int SW       = 32;

   localparam logic signed [15:0]   SAT_MAX   = 16'sh7FFF;
   localparam logic signed [15:0]   SAT_MIN   = 16'sh8000;
   localparam logic signed [SW-1:0] SAT_MAX_W = 32'sd32767;
   localparam logic signed [SW-1:0] SAT_MIN_W = -32'sd32768;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DIFF  = 3'd1,
      MUL_P = 3'd2,
      MUL_I = 3'd3,
      MUL_D = 3'd4,
      DONE  = 3'd5
   } pid_state_e;

   function automatic logic signed [SW-1:0] sext18(input logic [17:0] v);
      return {{(SW-18){v[17]}}, v};
   endfunction

   function automatic logic sat16_ovf(input logic signed [SW-1:0] x);
      return (x > SAT_MAX_W) || (x < SAT_MIN_W);
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] x);
      if (x > SAT_MAX_W) begin
         return SAT_MAX;
      end else if (x < SAT_MIN_W) begin
         return SAT_MIN;
      end else begin
         return x[15:0];
      end
   endfunction

endpackage

// File: rtl/pid_mul_sat.sv
// Shared coefficient multiplier: signed CW x DW product, floor shift by FRAC, clamp to DW bits.
module pid_mul_sat
   import pid_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int CW   = CW_DEF,
   parameter int FRAC = FRAC_DEF
) (
   input  logic signed [CW-1:0] coef,
   input  logic signed [DW-1:0] opnd,
   output logic signed [DW-1:0] res,
   output logic                 ovf
);

   logic signed [CW+DW-1:0] coef_x_s;
   logic signed [CW+DW-1:0] opnd_x_s;
   logic signed [CW+DW-1:0] prod_s;
   logic signed [CW+DW-1:0] shft_s;

   // Operands are sign-extended first so the full product fits without overflow.
   assign coef_x_s = {{DW{coef[CW-1]}}, coef};
   assign opnd_x_s = {{CW{opnd[DW-1]}}, opnd};
   assign prod_s   = coef_x_s * opnd_x_s;
   assign shft_s   = prod_s >>> FRAC;
   assign res      = sat16(shft_s);
   assign ovf      = sat16_ovf(shft_s);

endmodule

// File: rtl/pid_term_gen.sv
// Incremental PID term generator: one sample per six cycles, P/I/D terms through one shared multiplier.
// Optional macro PID_TERM_DEADBAND_EN zeroes errors within +/-DEADBAND before use.
module pid_term_gen
   import pid_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int CW   = CW_DEF,
   parameter int FRAC = FRAC_DEF
`ifdef PID_TERM_DEADBAND_EN
   ,
   parameter int DEADBAND = 4
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] setpoint,
   input  logic signed [DW-1:0] feedback,
   input  logic signed [CW-1:0] kp,
   input  logic signed [CW-1:0] ki,
   input  logic signed [CW-1:0] kd,
   input  logic                 clear_hist,
   output logic                 out_valid,
   output logic signed [DW-1:0] p_term,
   output logic signed [DW-1:0] i_term,
   output logic signed [DW-1:0] d_term,
   output logic                 sat
);

   pid_state_e state_r;

   logic signed [DW-1:0] sp_r;
   logic signed [DW-1:0] fb_r;
   logic signed [CW-1:0] kp_r;
   logic signed [CW-1:0] ki_r;
   logic signed [CW-1:0] kd_r;
   logic signed [DW-1:0] e_r;
   logic signed [DW-1:0] e1_r;
   logic signed [DW-1:0] e2_r;
   logic signed [DW-1:0] dp_r;
   logic signed [DW-1:0] dd_r;
   logic signed [DW-1:0] p_hold_r;
   logic signed [DW-1:0] i_hold_r;
   logic                 sat_acc_r;

   logic [DW:0]          e_wide_s;
   logic signed [DW-1:0] e_sat_s;
   logic                 e_ovf_s;
   logic signed [DW-1:0] e_db_s;
   logic [DW:0]          dp_wide_s;
   logic [DW+1:0]        dd_wide_s;
   logic signed [DW-1:0] dp_sat_s;
   logic                 dp_ovf_s;
   logic signed [DW-1:0] dd_sat_s;
   logic                 dd_ovf_s;

   logic signed [CW-1:0] mul_coef_s;
   logic signed [DW-1:0] mul_opnd_s;
   logic signed [DW-1:0] mul_res_s;
   logic                 mul_ovf_s;

   // Differences are formed one bit wider (two for dd) so clamping sees the true value.
   assign e_wide_s  = {sp_r[DW-1], sp_r} - {fb_r[DW-1], fb_r};
   assign e_sat_s   = sat16(sext18({e_wide_s[DW], e_wide_s}));
   assign e_ovf_s   = sat16_ovf(sext18({e_wide_s[DW], e_wide_s}));

`ifdef PID_TERM_DEADBAND_EN
   localparam logic signed [DW-1:0] DB_POS = DW'(DEADBAND);
   localparam logic signed [DW-1:0] DB_NEG = -DB_POS;

   // Small errors are treated as exactly zero, including in the stored history.
   always_comb begin
      if ((e_sat_s >= DB_NEG) && (e_sat_s <= DB_POS)) begin
         e_db_s = {DW{1'b0}};
      end else begin
         e_db_s = e_sat_s;
      end
   end
`else
   assign e_db_s = e_sat_s;
`endif

   assign dp_wide_s = {e_db_s[DW-1], e_db_s} - {e1_r[DW-1], e1_r};
   assign dd_wide_s = {{2{e_db_s[DW-1]}}, e_db_s} - {e1_r[DW-1], e1_r, 1'b0}
                    + {{2{e2_r[DW-1]}}, e2_r};
   assign dp_sat_s  = sat16(sext18({dp_wide_s[DW], dp_wide_s}));
   assign dp_ovf_s  = sat16_ovf(sext18({dp_wide_s[DW], dp_wide_s}));
   assign dd_sat_s  = sat16(sext18(dd_wide_s));
   assign dd_ovf_s  = sat16_ovf(sext18(dd_wide_s));

   // Operand select for the shared multiplier, one term per multiply state.
   always_comb begin
      mul_coef_s = {CW{1'b0}};
      mul_opnd_s = {DW{1'b0}};
      case (state_r)
         MUL_P: begin
            mul_coef_s = kp_r;
            mul_opnd_s = dp_r;
         end
         MUL_I: begin
            mul_coef_s = ki_r;
            mul_opnd_s = e_r;
         end
         MUL_D: begin
            mul_coef_s = kd_r;
            mul_opnd_s = dd_r;
         end
         default: begin
            mul_coef_s = {CW{1'b0}};
            mul_opnd_s = {DW{1'b0}};
         end
      endcase
   end

   pid_mul_sat #(
      .DW   (DW),
      .CW   (CW),
      .FRAC (FRAC)
   ) u_mul (
      .coef (mul_coef_s),
      .opnd (mul_opnd_s),
      .res  (mul_res_s),
      .ovf  (mul_ovf_s)
   );

   // Sequencer, operand latches, error history and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         sp_r      <= {DW{1'b0}};
         fb_r      <= {DW{1'b0}};
         kp_r      <= {CW{1'b0}};
         ki_r      <= {CW{1'b0}};
         kd_r      <= {CW{1'b0}};
         e_r       <= {DW{1'b0}};
         e1_r      <= {DW{1'b0}};
         e2_r      <= {DW{1'b0}};
         dp_r      <= {DW{1'b0}};
         dd_r      <= {DW{1'b0}};
         p_hold_r  <= {DW{1'b0}};
         i_hold_r  <= {DW{1'b0}};
         sat_acc_r <= 1'b0;
         p_term    <= {DW{1'b0}};
         i_term    <= {DW{1'b0}};
         d_term    <= {DW{1'b0}};
         sat       <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               out_valid <= 1'b0;
               // A clear with a concurrent accept lands before DIFF reads the history.
               if (clear_hist) begin
                  e1_r <= {DW{1'b0}};
                  e2_r <= {DW{1'b0}};
               end
               if (in_valid) begin
                  sp_r     <= setpoint;
                  fb_r     <= feedback;
                  kp_r     <= kp;
                  ki_r     <= ki;
                  kd_r     <= kd;
                  in_ready <= 1'b0;
                  state_r  <= DIFF;
               end else begin
                  in_ready <= 1'b1;
                  state_r  <= IDLE;
               end
            end
            DIFF: begin
               e_r       <= e_db_s;
               dp_r      <= dp_sat_s;
               dd_r      <= dd_sat_s;
               sat_acc_r <= e_ovf_s | dp_ovf_s | dd_ovf_s;
               state_r   <= MUL_P;
            end
            MUL_P: begin
               p_hold_r  <= mul_res_s;
               sat_acc_r <= sat_acc_r | mul_ovf_s;
               state_r   <= MUL_I;
            end
            MUL_I: begin
               i_hold_r  <= mul_res_s;
               sat_acc_r <= sat_acc_r | mul_ovf_s;
               state_r   <= MUL_D;
            end
            MUL_D: begin
               p_term    <= p_hold_r;
               i_term    <= i_hold_r;
               d_term    <= mul_res_s;
               sat       <= sat_acc_r | mul_ovf_s;
               out_valid <= 1'b1;
               e2_r      <= e1_r;
               e1_r      <= e_r;
               state_r   <= DONE;
            end
            DONE: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_r   <= IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pid_term_gen.sv
// Self-checking bench for pid_term_gen: directed plan cases plus randomized samples against an integer model.
module tb_pid_term_gen;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, clear_hist, out_valid, sat;
   logic [15:0] setpoint, feedback, kp, ki, kd;
   logic [15:0] p_term, i_term, d_term;

   int n_checks = 0;
   int n_pass   = 0;
   int m_e1 = 0;
   int m_e2 = 0;

   always #5 clk = ~clk;

   pid_term_gen dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .setpoint(setpoint), .feedback(feedback), .kp(kp), .ki(ki), .kd(kd),
      .clear_hist(clear_hist), .out_valid(out_valid),
      .p_term(p_term), .i_term(i_term), .d_term(d_term), .sat(sat)
   );

   typedef struct {int sp; int fb; int kp; int ki; int kd; bit clr; int p; int i; int d; bit s;} dvec_t;

   function automatic int clamp16(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return int'(x);
   endfunction

   function automatic longint floor_div256(input longint a);
      longint q;
      q = a / 256;
      if ((a % 256) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   // Reference: arithmetic straight from the term definitions, history kept as plain integers.
   task automatic model_step(input int sp, fb, kpv, kiv, kdv, input bit clr,
                             output int ep, ei, ed, output bit es);
      longint raw;
      int e, dp, dd;
      es = 1'b0;
      if (clr) begin m_e1 = 0; m_e2 = 0; end
      raw = longint'(sp) - fb;              e  = clamp16(raw); es |= (e != raw);
`ifdef PID_TERM_DEADBAND_EN
      if (e >= -4 && e <= 4) e = 0;
`endif
      raw = longint'(e) - m_e1;             dp = clamp16(raw); es |= (dp != raw);
      raw = longint'(e) - 2 * m_e1 + m_e2;  dd = clamp16(raw); es |= (dd != raw);
      raw = floor_div256(longint'(kpv) * dp); ep = clamp16(raw); es |= (ep != raw);
      raw = floor_div256(longint'(kiv) * e);  ei = clamp16(raw); es |= (ei != raw);
      raw = floor_div256(longint'(kdv) * dd); ed = clamp16(raw); es |= (ed != raw);
      m_e2 = m_e1;
      m_e1 = e;
   endtask

   // Drives one accepted sample and returns what the DUT showed on its output pulse.
   task automatic run_sample(input int sp, fb, kpv, kiv, kdv, input bit clr, busy_clr,
                             output int lat, output logic [15:0] p, i, d,
                             output logic s, ov_next);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      setpoint = sp[15:0]; feedback = fb[15:0];
      kp = kpv[15:0]; ki = kiv[15:0]; kd = kdv[15:0];
      in_valid = 1'b1; clear_hist = clr;
      @(negedge clk);
      in_valid = 1'b0; clear_hist = busy_clr; lat = 1;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      p = p_term; i = i_term; d = d_term; s = sat;
      clear_hist = 1'b0;
      @(negedge clk);
      ov_next = out_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; clear_hist = 1'b0;
      setpoint = '0; feedback = '0; kp = '0; ki = '0; kd = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      m_e1 = 0; m_e2 = 0;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++;
      if ({p_term, i_term, d_term, sat} !== 49'd0)
         $display("FAIL reset_terms: got p=%0d i=%0d d=%0d sat=%b want all 0",
                  $signed(p_term), $signed(i_term), $signed(d_term), sat);
      else n_pass++;
   endtask

   task automatic test_directed();
      dvec_t tbl[4] = '{
         '{1000, 400, 256,   0,   0, 1'b0,  600,  0,   0, 1'b0},
         '{1000, 700, 256,   0,   0, 1'b0, -300,  0,   0, 1'b0},
         '{1000, 700,   0,   0, 256, 1'b0,    0,  0, 300, 1'b0},
         '{   0,   3,   0, 128,   0, 1'b0,    0, -2,   0, 1'b0}};
      int lat, ep, ei, ed; bit es; logic [15:0] p, i, d; logic s, ovn;
      foreach (tbl[k]) begin
         run_sample(tbl[k].sp, tbl[k].fb, tbl[k].kp, tbl[k].ki, tbl[k].kd, tbl[k].clr, 1'b0,
                    lat, p, i, d, s, ovn);
         model_step(tbl[k].sp, tbl[k].fb, tbl[k].kp, tbl[k].ki, tbl[k].kd, tbl[k].clr, ep, ei, ed, es);
         n_checks++; if (lat != 5) $display("FAIL dir%0d_latency: got %0d want 5", k, lat); else n_pass++;
         n_checks++;
         if (p !== 16'(tbl[k].p) || i !== 16'(tbl[k].i) || d !== 16'(tbl[k].d) || s !== tbl[k].s)
            $display("FAIL dir%0d_terms: got p=%0d i=%0d d=%0d sat=%b want p=%0d i=%0d d=%0d sat=%b",
                     k, $signed(p), $signed(i), $signed(d), s, tbl[k].p, tbl[k].i, tbl[k].d, tbl[k].s);
         else n_pass++;
         n_checks++; if (ovn !== 1'b0) $display("FAIL dir%0d_pulse: got out_valid=%b after pulse want 0", k, ovn); else n_pass++;
      end
   endtask

   task automatic test_saturation();
      dvec_t tbl[3] = '{
         '{32767, -32768,   256, 0, 0, 1'b0,  32767, 0, 0, 1'b1},
         '{ 1000,      0, 32767, 0, 0, 1'b1,  32767, 0, 0, 1'b1},
         '{-1000,      0, 32767, 0, 0, 1'b1, -32768, 0, 0, 1'b1}};
      int lat, ep, ei, ed; bit es; logic [15:0] p, i, d; logic s, ovn;
      foreach (tbl[k]) begin
         run_sample(tbl[k].sp, tbl[k].fb, tbl[k].kp, tbl[k].ki, tbl[k].kd, tbl[k].clr, 1'b0,
                    lat, p, i, d, s, ovn);
         model_step(tbl[k].sp, tbl[k].fb, tbl[k].kp, tbl[k].ki, tbl[k].kd, tbl[k].clr, ep, ei, ed, es);
         n_checks++;
         if (p !== 16'(tbl[k].p) || i !== 16'(tbl[k].i) || d !== 16'(tbl[k].d) || s !== tbl[k].s)
            $display("FAIL sat%0d_terms: got p=%0d i=%0d d=%0d sat=%b want p=%0d i=%0d d=%0d sat=%b",
                     k, $signed(p), $signed(i), $signed(d), s, tbl[k].p, tbl[k].i, tbl[k].d, tbl[k].s);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int sp, fb, kpv, kiv, kdv, ep, ei, ed, low, seen, w;
      bit es;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      in_valid = 1'b1; clear_hist = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sp = int'($urandom_range(65535)) - 32768; fb = int'($urandom_range(65535)) - 32768;
         kpv = int'($urandom_range(1023)) - 512; kiv = int'($urandom_range(1023)) - 512;
         kdv = int'($urandom_range(1023)) - 512;
         setpoint = sp[15:0]; feedback = fb[15:0]; kp = kpv[15:0]; ki = kiv[15:0]; kd = kdv[15:0];
         model_step(sp, fb, kpv, kiv, kdv, 1'b0, ep, ei, ed, es);
         low = 0; seen = 0;
         @(negedge clk);
         while (!in_ready && low < 20) begin
            low++;
            if (out_valid) begin
               seen++;
               n_checks++;
               if (p_term !== 16'(ep) || i_term !== 16'(ei) || d_term !== 16'(ed) || sat !== es)
                  $display("FAIL b2b%0d_terms: got p=%0d i=%0d d=%0d sat=%b want p=%0d i=%0d d=%0d sat=%b",
                           k, $signed(p_term), $signed(i_term), $signed(d_term), sat, ep, ei, ed, es);
               else n_pass++;
            end
            @(negedge clk);
         end
         n_checks++; if (low != 5) $display("FAIL b2b%0d_busy_cycles: got %0d want 5", k, low); else n_pass++;
         n_checks++; if (seen != 1) $display("FAIL b2b%0d_pulses: got %0d want 1", k, seen); else n_pass++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat, ep, ei, ed, ov_cnt; bit es; logic [15:0] p, i, d; logic s, ovn;
      @(negedge clk);
      setpoint = 16'd500; feedback = 16'd100; kp = 16'h0100; ki = 16'h0100; kd = 16'h0100;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_e1 = 0; m_e2 = 0;
      ov_cnt = 0;
      repeat (8) begin @(negedge clk); if (out_valid) ov_cnt++; end
      n_checks++; if (ov_cnt != 0) $display("FAIL rstmid_no_valid: got %0d pulses want 0", ov_cnt); else n_pass++;
      n_checks++;
      if ({p_term, i_term, d_term, sat} !== 49'd0 || in_ready !== 1'b1)
         $display("FAIL rstmid_outputs: got p=%0d i=%0d d=%0d sat=%b rdy=%b want 0 0 0 0 1",
                  $signed(p_term), $signed(i_term), $signed(d_term), sat, in_ready);
      else n_pass++;
      run_sample(300, 0, 256, 256, 256, 1'b0, 1'b0, lat, p, i, d, s, ovn);
      model_step(300, 0, 256, 256, 256, 1'b0, ep, ei, ed, es);
      n_checks++;
      if (p !== 16'd300 || i !== 16'd300 || d !== 16'd300 || s !== 1'b0)
         $display("FAIL rstmid_history: got p=%0d i=%0d d=%0d sat=%b want 300 300 300 0",
                  $signed(p), $signed(i), $signed(d), s);
      else n_pass++;
   endtask

   task automatic test_clear_hist();
      int lat, ep, ei, ed; bit es; logic [15:0] p, i, d; logic s, ovn;
      run_sample(200, 0, 256, 0, 0, 1'b0, 1'b0, lat, p, i, d, s, ovn);
      model_step(200, 0, 256, 0, 0, 1'b0, ep, ei, ed, es);
      run_sample(50, 0, 256, 0, 256, 1'b1, 1'b0, lat, p, i, d, s, ovn);
      model_step(50, 0, 256, 0, 256, 1'b1, ep, ei, ed, es);
      n_checks++;
      if (p !== 16'd50 || d !== 16'd50) $display("FAIL clr_accept: got p=%0d d=%0d want 50 50", $signed(p), $signed(d));
      else n_pass++;
      @(negedge clk); clear_hist = 1'b1;
      @(negedge clk); clear_hist = 1'b0;
      m_e1 = 0; m_e2 = 0;
      run_sample(70, 0, 256, 0, 256, 1'b0, 1'b0, lat, p, i, d, s, ovn);
      model_step(70, 0, 256, 0, 256, 1'b0, ep, ei, ed, es);
      n_checks++;
      if (p !== 16'd70 || d !== 16'd70) $display("FAIL clr_idle: got p=%0d d=%0d want 70 70", $signed(p), $signed(d));
      else n_pass++;
      run_sample(30, 0, 256, 0, 256, 1'b0, 1'b1, lat, p, i, d, s, ovn);
      model_step(30, 0, 256, 0, 256, 1'b0, ep, ei, ed, es);
      n_checks++;
      if (p !== -16'sd40 || d !== -16'sd110) $display("FAIL clr_busy_cur: got p=%0d d=%0d want -40 -110", $signed(p), $signed(d));
      else n_pass++;
      run_sample(30, 0, 256, 0, 256, 1'b0, 1'b0, lat, p, i, d, s, ovn);
      model_step(30, 0, 256, 0, 256, 1'b0, ep, ei, ed, es);
      n_checks++;
      if (p !== 16'd0 || d !== 16'd40) $display("FAIL clr_busy_next: got p=%0d d=%0d want 0 40", $signed(p), $signed(d));
      else n_pass++;
   endtask

   task automatic test_random();
      int sp, fb, kpv, kiv, kdv, lat, ep, ei, ed; bit es, clr;
      logic [15:0] p, i, d; logic s, ovn;
      for (int k = 0; k < 24; k++) begin
         sp = int'($urandom_range(65535)) - 32768; fb = int'($urandom_range(65535)) - 32768;
         if (k % 2 == 0) begin sp = sp / 64; fb = fb / 64; end
         kpv = int'($urandom_range(65535)) - 32768; kiv = int'($urandom_range(2047)) - 1024;
         kdv = int'($urandom_range(511)) - 256;
         clr = ($urandom_range(7) == 0);
         run_sample(sp, fb, kpv, kiv, kdv, clr, 1'b0, lat, p, i, d, s, ovn);
         model_step(sp, fb, kpv, kiv, kdv, clr, ep, ei, ed, es);
         n_checks++;
         if (lat != 5 || p !== 16'(ep) || i !== 16'(ei) || d !== 16'(ed) || s !== es)
            $display("FAIL rnd%0d: got lat=%0d p=%0d i=%0d d=%0d sat=%b want lat=5 p=%0d i=%0d d=%0d sat=%b",
                     k, lat, $signed(p), $signed(i), $signed(d), s, ep, ei, ed, es);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_saturation();
      test_back_to_back();
      test_reset_mid();
      test_clear_hist();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
